mem_bridge: RTL

- Sequencer between the rv32i `core` and one single-port, word-wide memory with request/acknowledge handshake.
- Fetches the instruction at `pc_address_out` and holds it on `instr_out`.
- If the decoded instruction needs a data access, performs that load/store next.
- Then pulses `valid` once so the core commits and advances its PC.
- Owns all wait-state handling and ack-timeout recovery.

---
 rtl/mem_bridge.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/mem_bridge.sv
// Instruction-fetch / data-access sequencer between an rv32i core and a single-port
// word memory with req/ack handshake, wait-state handling and ack-timeout recovery.
module mem_bridge #(
    parameter int unsigned TIMEOUT   = 16,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_address_out,
    input  logic        request,
    input  logic        load,
    input  logic        store,
    input  logic [31:0] alu_out,
    input  logic [31:0] byte_accessS,
    input  logic [3:0]  masking_byte,
    output logic [31:0] instr_out,
    output logic [31:0] dataMem_out,
    output logic        valid,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        bus_err
);

    localparam int unsigned    CNT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [31:0]    WORD_MASK = 32'hFFFF_FFFC;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_DATA,
        S_COMMIT
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             cap_load, cap_load_next;
    logic [31:0]      instr_next, data_next, addr_next, wdata_next;
    logic [3:0]       wmask_next;
    logic             valid_next, req_next, we_next, bus_err_next;
    logic             acked, expired;

    // An ack only counts while a request is outstanding; ack beats timeout.
    assign acked   = mem_req && mem_ack;
    assign expired = mem_req && !mem_ack && (cnt == CNT_LAST);

    // Every output is a register, so this block computes the value each one takes
    // on the same edge that moves the FSM into the state that shows it.
    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves one unassigned (no latches).
        state_next    = state;
        cnt_next      = cnt;
        cap_load_next = cap_load;
        instr_next    = instr_out;
        data_next     = dataMem_out;
        valid_next    = 1'b0;
        bus_err_next  = bus_err;
        req_next      = mem_req;
        we_next       = mem_we;
        addr_next     = mem_addr;
        wdata_next    = mem_wdata;
        wmask_next    = mem_wmask;

        unique case (state)
            S_IDLE: state_next = S_FETCH;

            S_FETCH: begin
                if (acked) begin
                    instr_next = mem_rdata;
                    req_next   = 1'b0;
                    state_next = S_DECODE;
                end else if (expired) begin
                    instr_next   = NOP_INSTR;
                    bus_err_next = 1'b1;
                    req_next     = 1'b0;
                    state_next   = S_DECODE;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end

            S_DECODE: begin
                cap_load_next = load & ~store;
                if (request) begin
                    req_next   = 1'b1;
                    we_next    = store;
                    addr_next  = alu_out & WORD_MASK;
                    wdata_next = byte_accessS;
                    wmask_next = store ? masking_byte : 4'b0000;
                    cnt_next   = '0;
                    state_next = S_DATA;
                end else begin
                    valid_next = 1'b1;
                    state_next = S_COMMIT;
                end
            end

            S_DATA: begin
                if (acked) begin
                    if (cap_load) data_next = mem_rdata;
                    req_next   = 1'b0;
                    valid_next = 1'b1;
                    state_next = S_COMMIT;
                end else if (expired) begin
                    if (cap_load) data_next = '0;
                    bus_err_next = 1'b1;
                    req_next     = 1'b0;
                    valid_next   = 1'b1;
                    state_next   = S_COMMIT;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end

            S_COMMIT: state_next = S_FETCH;

            default: state_next = S_IDLE;
        endcase

        // Entering a fetch launches the request with the word-aligned PC.
        if (state != S_FETCH && state_next == S_FETCH) begin
            req_next   = 1'b1;
            we_next    = 1'b0;
            wmask_next = 4'b0000;
            addr_next  = pc_address_out & WORD_MASK;
            cnt_next   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            cap_load    <= 1'b0;
            instr_out   <= NOP_INSTR;
            dataMem_out <= '0;
            valid       <= 1'b0;
            bus_err     <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_wmask   <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so all of them update together.
            state       <= state_next;
            cnt         <= cnt_next;
            cap_load    <= cap_load_next;
            instr_out   <= instr_next;
            dataMem_out <= data_next;
            valid       <= valid_next;
            bus_err     <= bus_err_next;
            mem_req     <= req_next;
            mem_we      <= we_next;
            mem_addr    <= addr_next;
            mem_wdata   <= wdata_next;
            mem_wmask   <= wmask_next;
        end
    end

    a_valid_single: assert property (@(posedge clk) disable iff (!rst) valid |=> !valid);

    a_payload_stable: assert property (@(posedge clk) disable iff (!rst)
        (mem_req && $past(mem_req)) |-> $stable({mem_we, mem_addr, mem_wdata, mem_wmask}));

endmodule
